// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, default widths
// and the NOP field values the decoder injects for a bubble.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEF  = 4;
  localparam int unsigned FETCH_CNT_W = 2;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_EXE   = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;
  localparam logic [1:0] ST_FETCH = 2'd3;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    EXE   = ST_EXE,
    WB    = ST_WB,
    FETCH = ST_FETCH
  } seqState_t;

  // Field values loaded into Dec/Exe when a bubble is inserted
  localparam logic NOP_HAS_WB  = 1'b0;
  localparam logic NOP_IS_CTRL = 1'b0;

endpackage

// File: rtl/pipe_hazard_sequencer_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Central sequencer for the decode/execute/writeback pipeline: buffer and PC
// write enables, branch bubbles, redirect select and operand forwarding.
module pipe_hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW    = REG_AW_DEF,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned FETCH_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dec_is_ctrl,
  input  logic              exe_taken,
  input  logic              wb_has_wb,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [REG_AW-1:0] exe_src_a,
  input  logic [REG_AW-1:0] exe_src_b,
  output logic              dec_exe_wr,
  output logic              dec_bubble,
  output logic              exe_wb_wr,
  output logic              pc_wr,
  output logic              pc_sel_ext,
  output logic              reg_wr_en,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  seqState_t              state, stateNext;
  logic                   takenQ, takenNext;
  logic [FETCH_CNT_W-1:0] fetchCnt, fetchCntNext;
  logic [CNT_W-1:0]       stallQ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      takenQ   <= 1'b0;
      fetchCnt <= '0;
    end else begin
      state    <= stateNext;
      takenQ   <= takenNext;
      fetchCnt <= fetchCntNext;
    end
  end

  // Next state and pipeline enables; reset forces every enable low
  always_comb begin
    stateNext    = RUN;
    takenNext    = takenQ;
    fetchCntNext = fetchCnt;
    dec_exe_wr   = 1'b1;
    exe_wb_wr    = 1'b1;
    dec_bubble   = 1'b0;
    pc_wr        = 1'b0;
    pc_sel_ext   = 1'b0;
    case (state)
      RUN: begin
        pc_wr     = ~dec_is_ctrl;
        stateNext = dec_is_ctrl ? EXE : RUN;
      end
      EXE: begin
        dec_bubble = 1'b1;
        takenNext  = exe_taken;
        stateNext  = WB;
      end
      WB: begin
        dec_bubble = 1'b1;
        pc_wr      = 1'b1;
        pc_sel_ext = takenQ;
        if (FETCH_LAT == 0) begin
          stateNext = RUN;
        end else begin
          stateNext    = FETCH;
          fetchCntNext = FETCH_CNT_W'(FETCH_LAT - 1);
        end
      end
      FETCH: begin
        dec_bubble = 1'b1;
        if (fetchCnt == '0) begin
          stateNext = RUN;
        end else begin
          stateNext    = FETCH;
          fetchCntNext = fetchCnt - FETCH_CNT_W'(1);
        end
      end
      default: stateNext = RUN;
    endcase
    if (RST) begin
      dec_exe_wr = 1'b0;
      exe_wb_wr  = 1'b0;
      dec_bubble = 1'b0;
      pc_wr      = 1'b0;
      pc_sel_ext = 1'b0;
    end
  end

  assign reg_wr_en = wb_has_wb & ~RST;
  assign fwd_a     = ~RST & wb_has_wb & (wb_dest == exe_src_a);
  assign fwd_b     = ~RST & wb_has_wb & (wb_dest == exe_src_b);
  assign busy      = ~RST & (state != RUN);
  assign stall_cnt = RST ? '0 : stallQ;

  sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
    .CLK (CLK),
    .RST (RST),
    .inc (dec_bubble),
    .q   (stallQ)
  );

endmodule
